// File: rtl/alu_bitserial_ctrl_if.sv
// Request/response and slice-control bundle for the bit-serial ALU controller.
// master is the environment side (CPU decode plus the 1-bit slice); slave is the controller.
interface alu_bitserial_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [3:0]       ctrl_i;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] result_o;
  logic             zero_o;
  logic             cout_o;
  logic             overflow_o;
  logic             slice_src1_o;
  logic             slice_src2_o;
  logic             slice_less_o;
  logic             slice_ainvert_o;
  logic             slice_binvert_o;
  logic             slice_cin_o;
  logic [1:0]       slice_op_o;
  logic             slice_result_i;
  logic             slice_cout_i;

  modport master (
    output start_i, ctrl_i, src1_i, src2_i, slice_result_i, slice_cout_i,
    input  busy_o, done_o, result_o, zero_o, cout_o, overflow_o,
    input  slice_src1_o, slice_src2_o, slice_less_o, slice_ainvert_o,
    input  slice_binvert_o, slice_cin_o, slice_op_o
  );

  modport slave (
    input  start_i, ctrl_i, src1_i, src2_i, slice_result_i, slice_cout_i,
    output busy_o, done_o, result_o, zero_o, cout_o, overflow_o,
    output slice_src1_o, slice_src2_o, slice_less_o, slice_ainvert_o,
    output slice_binvert_o, slice_cin_o, slice_op_o
  );
endinterface

// File: rtl/alu_bitserial_ctrl.sv
// Drives one external 1-bit ALU slice LSB-first to run a WIDTH-bit ALU operation,
// chaining the slice carry-out back in and assembling result and flags.
//
// state   | meaning
// S_IDLE  | waiting for start; slice controls held at 0
// S_PASS1 | main pass, one bit per cycle (SLT runs a subtract here)
// S_PASS2 | SLT only: LESS pass, set bit injected at bit 0
// S_DONE  | one-cycle done pulse, outputs already updated
module alu_bitserial_ctrl #(
  parameter int WIDTH = 32
) (
  input logic                clk_i,
  input logic                rst_i,
  alu_bitserial_ctrl_if.slave bus
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  localparam logic [3:0] C_AND = 4'b0000;
  localparam logic [3:0] C_OR  = 4'b0001;
  localparam logic [3:0] C_ADD = 4'b0010;
  localparam logic [3:0] C_SUB = 4'b0110;
  localparam logic [3:0] C_SLT = 4'b0111;
  localparam logic [3:0] C_NOR = 4'b1100;

  localparam logic [1:0] OP_OR   = 2'b00;
  localparam logic [1:0] OP_AND  = 2'b01;
  localparam logic [1:0] OP_SUM  = 2'b10;
  localparam logic [1:0] OP_LESS = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PASS1 = 2'd1,
    S_PASS2 = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q;
  state_t           state_d;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_next;
  logic [3:0]       ctrl_q;
  logic [CW-1:0]    idx_q;
  logic             carry_q;
  logic             cout_q;
  logic             set_q;

  logic             last_bit;
  logic             first_bit;
  logic             start_legal;
  logic             is_slt;
  logic             is_arith;
  logic             dec_ainv;
  logic             dec_binv;
  logic [1:0]       dec_op;
  logic             cin;

  function automatic logic ctrl_legal(input logic [3:0] c);
    case (c)
      C_AND, C_OR, C_ADD, C_SUB, C_SLT, C_NOR: return 1'b1;
      default:                                 return 1'b0;
    endcase
  endfunction

  assign last_bit    = (idx_q == LAST);
  assign first_bit   = (idx_q == '0);
  assign start_legal = ctrl_legal(bus.ctrl_i);
  assign is_slt      = (ctrl_q == C_SLT);
  assign is_arith    = (ctrl_q == C_ADD) || (ctrl_q == C_SUB);

  // Pass-1 slice controls; SLT reuses the subtract setting.
  always_comb begin
    dec_ainv = 1'b0;
    dec_binv = 1'b0;
    dec_op   = OP_OR;
    case (ctrl_q)
      C_AND: dec_op = OP_AND;
      C_OR:  dec_op = OP_OR;
      C_ADD: dec_op = OP_SUM;
      C_SUB: begin
        dec_binv = 1'b1;
        dec_op   = OP_SUM;
      end
      C_SLT: begin
        dec_binv = 1'b1;
        dec_op   = OP_SUM;
      end
      C_NOR: begin
        dec_ainv = 1'b1;
        dec_binv = 1'b1;
        dec_op   = OP_AND;
      end
      default: ;
    endcase
  end

  always_comb begin
    acc_next        = acc_q;
    acc_next[idx_q] = bus.slice_result_i;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          state_d = start_legal ? S_PASS1 : S_DONE;
        end
      end
      S_PASS1: begin
        if (last_bit) begin
          state_d = is_slt ? S_PASS2 : S_DONE;
        end
      end
      S_PASS2: begin
        if (last_bit) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy_o          = 1'b0;
    bus.done_o          = 1'b0;
    bus.slice_src1_o    = 1'b0;
    bus.slice_src2_o    = 1'b0;
    bus.slice_less_o    = 1'b0;
    bus.slice_ainvert_o = 1'b0;
    bus.slice_binvert_o = 1'b0;
    bus.slice_op_o      = OP_OR;
    cin                 = 1'b0;
    case (state_q)
      S_PASS1: begin
        bus.busy_o          = 1'b1;
        bus.slice_src1_o    = a_q[idx_q];
        bus.slice_src2_o    = b_q[idx_q];
        bus.slice_ainvert_o = dec_ainv;
        bus.slice_binvert_o = dec_binv;
        bus.slice_op_o      = dec_op;
        cin                 = first_bit ? dec_binv : carry_q;
      end
      S_PASS2: begin
        bus.busy_o       = 1'b1;
        bus.slice_src1_o = a_q[idx_q];
        bus.slice_src2_o = b_q[idx_q];
        bus.slice_op_o   = OP_LESS;
        bus.slice_less_o = first_bit & set_q;
        cin              = first_bit ? 1'b0 : carry_q;
      end
      S_DONE: begin
        bus.done_o = 1'b1;
      end
      default: ;
    endcase
    bus.slice_cin_o = cin;
  end

  // Result and flags are only written on the edge entering S_DONE, so they hold between operations.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      a_q            <= '0;
      b_q            <= '0;
      acc_q          <= '0;
      ctrl_q         <= '0;
      idx_q          <= '0;
      carry_q        <= 1'b0;
      cout_q         <= 1'b0;
      set_q          <= 1'b0;
      bus.result_o   <= '0;
      bus.zero_o     <= 1'b0;
      bus.cout_o     <= 1'b0;
      bus.overflow_o <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start_i) begin
            if (start_legal) begin
              a_q     <= bus.src1_i;
              b_q     <= bus.src2_i;
              ctrl_q  <= bus.ctrl_i;
              idx_q   <= '0;
              carry_q <= 1'b0;
            end else begin
              bus.result_o   <= '0;
              bus.zero_o     <= 1'b0;
              bus.cout_o     <= 1'b0;
              bus.overflow_o <= 1'b0;
            end
          end
        end
        S_PASS1: begin
          acc_q   <= acc_next;
          carry_q <= bus.slice_cout_i;
          if (last_bit) begin
            idx_q  <= '0;
            cout_q <= bus.slice_cout_i;
            // SLT set bit: MSB of the difference corrected by signed overflow
            set_q  <= bus.slice_result_i ^ cin ^ bus.slice_cout_i;
            if (!is_slt) begin
              bus.result_o   <= acc_next;
              bus.zero_o     <= (acc_next == '0);
              bus.cout_o     <= is_arith & bus.slice_cout_i;
              bus.overflow_o <= is_arith & (cin ^ bus.slice_cout_i);
            end
          end else begin
            idx_q <= idx_q + CW'(1);
          end
        end
        S_PASS2: begin
          acc_q   <= acc_next;
          carry_q <= bus.slice_cout_i;
          if (last_bit) begin
            idx_q          <= '0;
            bus.result_o   <= acc_next;
            bus.zero_o     <= (acc_next == '0);
            bus.cout_o     <= cout_q;
            bus.overflow_o <= 1'b0;
          end else begin
            idx_q <= idx_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_bitserial_ctrl.sv
// Bench for alu_bitserial_ctrl: real 1-bit slice, arithmetic reference model and
// a per-cycle compare process, plus directed literal cases and randomized operations.
module tb_alu_bitserial_ctrl;
  localparam int W = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  alu_bitserial_ctrl_if #(.WIDTH(W)) bus ();

  alu_bitserial_ctrl #(.WIDTH(W)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // 1-bit ALU slice
  logic sa, sb;
  always_comb begin
    sa = bus.slice_src1_o ^ bus.slice_ainvert_o;
    sb = bus.slice_src2_o ^ bus.slice_binvert_o;
    bus.slice_cout_i = (sa & sb) | (sa & bus.slice_cin_o) | (sb & bus.slice_cin_o);
    case (bus.slice_op_o)
      2'b00:   bus.slice_result_i = sa | sb;
      2'b01:   bus.slice_result_i = sa & sb;
      2'b10:   bus.slice_result_i = sa ^ sb ^ bus.slice_cin_o;
      default: bus.slice_result_i = bus.slice_less_o;
    endcase
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%h required=0x%h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: what a full operation must produce, from plain arithmetic.
  task automatic model_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] r, output logic z, output logic co,
                          output logic ov, output int lat);
    logic [W:0] s;
    r   = '0;
    co  = 1'b0;
    ov  = 1'b0;
    lat = W + 1;
    case (c)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b1100: r = ~(a | b);
      4'b0010: begin
        s  = {1'b0, a} + {1'b0, b};
        r  = s[W-1:0];
        co = s[W];
        ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      4'b0110: begin
        s  = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        r  = s[W-1:0];
        co = s[W];
        ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      4'b0111: begin
        s   = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        co  = s[W];
        r   = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
        lat = 2 * W + 1;
      end
      default: lat = 1;
    endcase
    z = (r == '0) && (lat != 1);
  endtask

  function automatic logic [3:0] exp_ctl(input logic [3:0] c);
    case (c)
      4'b0000: return 4'b0001;
      4'b0001: return 4'b0000;
      4'b0010: return 4'b0010;
      4'b0110: return 4'b0110;
      4'b0111: return 4'b0110;
      4'b1100: return 4'b1101;
      default: return 4'b0000;
    endcase
  endfunction

  // Model state: m_rem counts cycles left until the done cycle (1 = done cycle, 0 = idle).
  int             m_rem = 0;
  int             m_lat = 0;
  logic [W-1:0]   m_a = '0, m_b = '0, m_res = '0, p_res = '0;
  logic [3:0]     m_ctrl = '0;
  logic           m_z = 0, m_c = 0, m_v = 0, p_z = 0, p_c = 0, p_v = 0;

  initial begin
    int bit_i;
    int idx;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_rem = 0;
        m_res = '0;
        m_z   = 1'b0;
        m_c   = 1'b0;
        m_v   = 1'b0;
      end else if (m_rem == 0) begin
        if (bus.start_i) begin
          m_a    = bus.src1_i;
          m_b    = bus.src2_i;
          m_ctrl = bus.ctrl_i;
          model_op(bus.ctrl_i, bus.src1_i, bus.src2_i, p_res, p_z, p_c, p_v, m_lat);
          m_rem = m_lat;
        end
      end else begin
        m_rem--;
      end
      if (m_rem == 1) begin
        m_res = p_res;
        m_z   = p_z;
        m_c   = p_c;
        m_v   = p_v;
      end

      check("done", W'(bus.done_o), W'(m_rem == 1));
      check("busy", W'(bus.busy_o), W'(m_rem > 1));
      check("result", bus.result_o, m_res);
      check("zero", W'(bus.zero_o), W'(m_z));
      check("cout", W'(bus.cout_o), W'(m_c));
      check("overflow", W'(bus.overflow_o), W'(m_v));
      if (m_rem == 0) begin
        check("slice_idle", W'({bus.slice_src1_o, bus.slice_src2_o, bus.slice_less_o,
                                bus.slice_ainvert_o, bus.slice_binvert_o, bus.slice_cin_o,
                                bus.slice_op_o}), W'(0));
      end else if (m_rem > 1) begin
        bit_i = m_lat - m_rem;
        idx   = (bit_i < W) ? bit_i : bit_i - W;
        check("slice_src1", W'(bus.slice_src1_o), W'(m_a[idx]));
        check("slice_src2", W'(bus.slice_src2_o), W'(m_b[idx]));
        check("slice_ctl", W'({bus.slice_ainvert_o, bus.slice_binvert_o, bus.slice_op_o}),
              W'((bit_i < W) ? exp_ctl(m_ctrl) : 4'b0011));
        check("slice_less", W'(bus.slice_less_o),
              W'((bit_i >= W) && (idx == 0) && p_res[0]));
      end
    end
  end

  // mode: 0 quiet, -1 random start noise while busy, >0 single start pulse at that cycle
  task automatic run_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int mode, output int lat);
    @(negedge clk);
    #1;
    bus.start_i = 1'b1;
    bus.ctrl_i  = c;
    bus.src1_i  = a;
    bus.src2_i  = b;
    lat = 0;
    for (int i = 1; i <= 2 * W + 8; i++) begin
      @(negedge clk);
      if (bus.done_o) begin
        lat = i;
        break;
      end
      #1;
      bus.start_i = 1'b0;
      if ((mode > 0 && i == mode) || (mode < 0 && $urandom_range(0, 3) == 0)) begin
        bus.start_i = 1'b1;
        bus.ctrl_i  = 4'($urandom_range(0, 15));
        bus.src1_i  = $urandom;
        bus.src2_i  = $urandom;
      end
    end
    #1;
    bus.start_i = 1'b0;
    if (lat == 0) check("done_timeout", W'(0), W'(1));
  endtask

  logic [3:0] ctrl_pool [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110,
                                4'b0111, 4'b1100, 4'b1111, 4'b0011};

  initial begin
    int lat;
    logic [W-1:0] a, b;
    bus.start_i = 1'b0;
    bus.ctrl_i  = '0;
    bus.src1_i  = '0;
    bus.src2_i  = '0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    run_op(4'b0010, 32'd7, 32'd5, 0, lat);
    check("add_res", bus.result_o, 32'h0000000C);
    check("add_cout", W'(bus.cout_o), W'(0));
    check("add_ovf", W'(bus.overflow_o), W'(0));
    check("add_latency", W'(lat), W'(33));

    run_op(4'b0110, 32'd5, 32'd7, 0, lat);
    check("sub_res", bus.result_o, 32'hFFFFFFFE);
    check("sub_cout", W'(bus.cout_o), W'(0));
    check("sub_zero", W'(bus.zero_o), W'(0));
    run_op(4'b0110, 32'd9, 32'd9, 0, lat);
    check("sub_eq_res", bus.result_o, 32'h0);
    check("sub_eq_zero", W'(bus.zero_o), W'(1));
    check("sub_eq_cout", W'(bus.cout_o), W'(1));

    run_op(4'b0010, 32'h7FFFFFFF, 32'h00000001, 0, lat);
    check("addov_res", bus.result_o, 32'h80000000);
    check("addov_ovf", W'(bus.overflow_o), W'(1));
    run_op(4'b1100, 32'h0F0F0F0F, 32'h00FF00FF, 0, lat);
    check("nor_res", bus.result_o, 32'hF000F000);

    run_op(4'b0111, 32'hFFFFFFFB, 32'h00000003, 0, lat);
    check("slt_neg_res", bus.result_o, 32'h1);
    run_op(4'b0111, 32'h80000000, 32'h00000001, 0, lat);
    check("slt_ovf_res", bus.result_o, 32'h1);
    check("slt_ovf_flag", W'(bus.overflow_o), W'(0));
    run_op(4'b0111, 32'd3, 32'd3, 0, lat);
    check("slt_eq_res", bus.result_o, 32'h0);
    check("slt_eq_zero", W'(bus.zero_o), W'(1));
    check("slt_latency", W'(lat), W'(65));

    run_op(4'b0010, 32'h1234, 32'h1111, 10, lat);
    check("add_ignore_start", bus.result_o, 32'h2345);
    run_op(4'b1111, 32'hDEAD, 32'hBEEF, 0, lat);
    check("illegal_res", bus.result_o, 32'h0);
    check("illegal_latency", W'(lat), W'(1));
    run_op(4'b0001, 32'hA5A50000, 32'h00005A5A, 0, lat);
    check("or_res", bus.result_o, 32'hA5A55A5A);

    // Abort a SUB at bit 12 with an asynchronous reset
    @(negedge clk);
    #1;
    bus.start_i = 1'b1;
    bus.ctrl_i  = 4'b0110;
    bus.src1_i  = 32'd1000;
    bus.src2_i  = 32'd1;
    @(negedge clk);
    #1 bus.start_i = 1'b0;
    repeat (12) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_done", W'(bus.done_o), W'(0));
    check("rst_busy", W'(bus.busy_o), W'(0));
    check("rst_result", bus.result_o, W'(0));
    check("rst_flags", W'({bus.zero_o, bus.cout_o, bus.overflow_o}), W'(0));
    check("rst_slice", W'({bus.slice_src1_o, bus.slice_src2_o, bus.slice_less_o,
                           bus.slice_ainvert_o, bus.slice_binvert_o, bus.slice_cin_o,
                           bus.slice_op_o}), W'(0));
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    run_op(4'b0010, 32'd100, 32'd23, 0, lat);
    check("post_rst_add", bus.result_o, 32'd123);

    for (int n = 0; n < 80; n++) begin
      a = $urandom;
      case ($urandom_range(0, 5))
        0:       b = a;
        1:       b = 32'h80000000;
        2:       b = 32'h7FFFFFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 4) == 0) a = 32'h80000000;
      run_op(ctrl_pool[$urandom_range(0, 7)], a, b, (n % 3 == 0) ? -1 : 0, lat);
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_bitserial_ctrl.md
Name: alu_bitserial_ctrl

Overview:
Multi-cycle initiator that drives one external 1-bit ALU slice, one bit per clock, to run a full WIDTH-bit ALU operation.
- Latches operands and an ALU control code on start.
- Sequences the slice controls and operand bits from LSB to MSB, feeding the slice's carry-out back as the next carry-in.
- Assembles the result and flags, then pulses done.
- Sits between the CPU's ALU-control decode and a single slice instance, in area-minimal datapaths.

Parameters:
WIDTH, 32, operand/result width in bits (>=2)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-low
start_i  in  1  request; accepted only in IDLE
ctrl_i  in  4  ALU control: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR
src1_i  in  WIDTH  operand A
src2_i  in  WIDTH  operand B
busy_o  out  1  high from the cycle after acceptance until done
done_o  out  1  one-cycle completion pulse
result_o  out  WIDTH  result; held until next done
zero_o  out  1  result_o == 0
cout_o  out  1  carry out of MSB (ADD/SUB/SLT), else 0
overflow_o  out  1  signed overflow (ADD/SUB), else 0
slice_src1_o  out  1  operand A bit to slice
slice_src2_o  out  1  operand B bit to slice
slice_less_o  out  1  less input to slice
slice_ainvert_o  out  1  Ainvert to slice
slice_binvert_o  out  1  Binvert to slice
slice_cin_o  out  1  carry-in to slice
slice_op_o  out  2  slice operation: 00 OR, 01 AND, 10 SUM, 11 LESS
slice_result_i  in  1  slice result, combinational, same cycle
slice_cout_i  in  1  slice carry-out, combinational, same cycle

Behaviour:
- Reset (async, rst_i=0):
  - State IDLE, bit counter 0, carry register 0.
  - All outputs 0: busy_o, done_o, result_o, zero_o, cout_o, overflow_o, all slice_* outputs.
  - Reset mid-operation aborts the operation; no done_o is produced.
- State IDLE:
  - All slice_* outputs are 0.
  - start_i=1 with a legal ctrl_i: latch src1_i, src2_i, ctrl_i; next state PASS1, bit index 0.
  - start_i=1 with an illegal ctrl_i: next cycle done_o=1, result_o=0, all flags 0; no slice pass is run.
- start_i while busy: ignored; latched operands are unchanged.
- Control mapping (Ainvert/Binvert/op):
  - AND = 0/0/01
  - OR = 0/0/00
  - ADD = 0/0/10
  - SUB = 0/1/10
  - NOR = 1/1/01
  - SLT pass 1 = 0/1/10; SLT pass 2 = 0/0/11
- State PASS1, bit i:
  - slice_src1_o = A[i], slice_src2_o = B[i].
  - slice_cin_o = Binvert when i=0, else the carry register.
  - On each edge: result bit i <= slice_result_i, carry register <= slice_cout_i, i increments.
  - At i=WIDTH-1, capture cout = slice_cout_i and overflow = slice_cin_o XOR slice_cout_i.
  - Next state after the MSB: PASS2 for SLT, otherwise DONE.
- State PASS2 (SLT only):
  - set = sum_MSB XOR overflow, both from PASS1.
  - slice_op_o = 11; slice_less_o = set at bit 0, 0 elsewhere; result bits come from slice_result_i.
  - SLT reports overflow_o = 0 and cout_o = PASS1 cout.
- State DONE (one cycle):
  - done_o=1, busy_o=0.
  - result_o, zero_o, cout_o and overflow_o update in this same cycle.
  - Next state IDLE.
- Latency, from the accepting edge to the done_o cycle:
  - WIDTH+1 cycles for AND/OR/ADD/SUB/NOR.
  - 2*WIDTH+1 cycles for SLT.
  - A new start is accepted on the cycle after DONE (back-to-back operations allowed).
- Width rules:
  - Counter width is clog2(WIDTH); the wrap at WIDTH-1 must not alias.
  - Carry is strictly 1 bit; no arithmetic is performed outside the slice.
- busy_o rises on the edge that accepts start and falls on entry to DONE.

Test Plan:
- ADD 7+5 (bench uses a real 1-bit slice instance) -> result_o=0x0000000C, cout_o=0, overflow_o=0, done_o exactly 33 cycles after acceptance.
- SUB 5-7 -> result_o=0xFFFFFFFE, cout_o=0, zero_o=0; SUB 9-9 -> result_o=0, zero_o=1, cout_o=1.
- ADD 0x7FFFFFFF+0x00000001 -> result_o=0x80000000, overflow_o=1; NOR 0x0F0F0F0F,0x00FF00FF -> result_o=0xF000F000.
- SLT 0xFFFFFFFB vs 0x00000003 -> result_o=1; SLT 0x80000000 vs 0x00000001 (overflow case) -> result_o=1; SLT 3 vs 3 -> result_o=0, zero_o=1; done_o at cycle 65.
- start_i pulsed at cycle 10 of an ADD -> ignored, first result correct; illegal ctrl_i 1111 -> done_o next cycle, result_o=0.
- rst_i low at bit 12 of a SUB -> all outputs 0 immediately and no done_o; a new ADD issued after release completes correctly.
